// File: rtl/segm_pkg.sv
// Shared seven-segment constants and decoder state type.
// Patterns are active-low, bit0=a .. bit6=g.
package segm_pkg;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    LOCKED
  } state_t;

  typedef struct packed {
    logic       is_digit;
    logic       is_blank;
    logic [3:0] hex;
  } lut_t;

  // Encoder-side helper sharing the same table.
  function automatic logic [6:0] hex2seg(
    input logic [3:0] h
  );
    logic [6:0] s;
    s = SEG_BLANK;
    case (h)
      4'h0: s = SEG_0;
      4'h1: s = SEG_1;
      4'h2: s = SEG_2;
      4'h3: s = SEG_3;
      4'h4: s = SEG_4;
      4'h5: s = SEG_5;
      4'h6: s = SEG_6;
      4'h7: s = SEG_7;
      4'h8: s = SEG_8;
      4'h9: s = SEG_9;
      4'hA: s = SEG_A;
      4'hB: s = SEG_B;
      4'hC: s = SEG_C;
      4'hD: s = SEG_D;
      4'hE: s = SEG_E;
      default: s = SEG_F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/segm_lut.sv
// Combinational segment-pattern lookup: seg -> {is_digit, is_blank, hex}.
// Ports: seg (7b pattern in), res (lut_t result out).
module segm_lut
  import segm_pkg::*;
(
  input  logic [6:0] seg,
  output lut_t       res
);

  always_comb begin
    res = '{is_digit: 1'b0,
            is_blank: 1'b0,
            hex:      4'h0};
    unique case (1'b1)
      (seg == SEG_0): res = '{1'b1, 1'b0, 4'h0};
      (seg == SEG_1): res = '{1'b1, 1'b0, 4'h1};
      (seg == SEG_2): res = '{1'b1, 1'b0, 4'h2};
      (seg == SEG_3): res = '{1'b1, 1'b0, 4'h3};
      (seg == SEG_4): res = '{1'b1, 1'b0, 4'h4};
      (seg == SEG_5): res = '{1'b1, 1'b0, 4'h5};
      (seg == SEG_6): res = '{1'b1, 1'b0, 4'h6};
      (seg == SEG_7): res = '{1'b1, 1'b0, 4'h7};
      (seg == SEG_8): res = '{1'b1, 1'b0, 4'h8};
      (seg == SEG_9): res = '{1'b1, 1'b0, 4'h9};
      (seg == SEG_A): res = '{1'b1, 1'b0, 4'hA};
      (seg == SEG_B): res = '{1'b1, 1'b0, 4'hB};
      (seg == SEG_C): res = '{1'b1, 1'b0, 4'hC};
      (seg == SEG_D): res = '{1'b1, 1'b0, 4'hD};
      (seg == SEG_E): res = '{1'b1, 1'b0, 4'hE};
      (seg == SEG_F): res = '{1'b1, 1'b0, 4'hF};
      (seg == SEG_BLANK):
        res = '{1'b0, 1'b1, 4'h0};
      default: ;
    endcase
  end

endmodule

// File: rtl/segm2hex.sv
// Seven-segment decoder/validator: syncs segm, requires STABLE_CYCLES
// equal samples, then drives hex/valid/err/change. Macro: SEGM2HEX_ERR_STICKY_EN.
// Ports: clk, rst_n (sync, active-low), segm[6:0] in; hex[3:0], valid, err, change out.
module segm2hex
  import segm_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] segm,
  output logic [3:0] hex,
  output logic       valid,
  output logic       err,
  output logic       change
);

  localparam logic [7:0] LAST = 8'(STABLE_CYCLES - 1);

  logic [6:0] s1;
  logic [6:0] s2;
  logic [6:0] cand;
  logic [7:0] cnt;
  state_t     state;
  lut_t       lut;
  logic       same;
  logic       accept;
  logic       illegal;
  logic       err_nxt;

  segm_lut u_lut (
    .seg (s2),
    .res (lut)
  );

  assign same    = (s2 == cand);
  assign accept  = (state == SETTLE) && same && (cnt >= LAST);
  assign illegal = !lut.is_digit && !lut.is_blank;

`ifdef SEGM2HEX_ERR_STICKY_EN
  assign err_nxt = err | illegal;
`else
  assign err_nxt = illegal;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1     <= SEG_BLANK;
      s2     <= SEG_BLANK;
      cand   <= SEG_BLANK;
      cnt    <= 8'd0;
      state  <= IDLE;
      hex    <= 4'h0;
      valid  <= 1'b0;
      err    <= 1'b0;
      change <= 1'b0;
    end else begin
      s1     <= segm;
      s2     <= s1;
      change <= 1'b0;
      if (!same) begin
        // Any new pattern restarts settling from one sample.
        cand  <= s2;
        cnt   <= 8'd1;
        state <= SETTLE;
      end else if (state == SETTLE) begin
        if (accept) begin
          state <= LOCKED;
          err   <= err_nxt;
          if (lut.is_digit) begin
            hex    <= lut.hex;
            valid  <= 1'b1;
            change <= !valid || (hex != lut.hex);
          end else begin
            valid  <= 1'b0;
          end
        end else begin
          cnt <= cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_segm2hex.sv
// Randomized + directed self-checking bench for segm2hex.
// Reference model tracks run lengths of synchronized samples.
module tb_segm2hex;

  localparam int S = 4;
`ifdef SEGM2HEX_ERR_STICKY_EN
  localparam bit STICKY = 1'b1;
`else
  localparam bit STICKY = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] segm = 7'h7F;
  logic [3:0] hex;
  logic       valid;
  logic       err;
  logic       change;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  segm2hex #(.STABLE_CYCLES(S)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .segm   (segm),
    .hex    (hex),
    .valid  (valid),
    .err    (err),
    .change (change)
  );

  always #5 clk = ~clk;

  logic [6:0] tbl [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30,
    7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03,
    7'h46, 7'h21, 7'h06, 7'h0E
  };

  // Model: two-sample delay line, then a run-length counter.
  logic [6:0] p1, p2, runv;
  int         runlen;
  bit         armed;
  logic [3:0] eh;
  logic       ev, ee, ech;

  task automatic check(input string nm,
                       input int act,
                       input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    logic [6:0] v;
    int d;
    if (!rst_n) begin
      p1 = 7'h7F; p2 = 7'h7F; runv = 7'h7F;
      runlen = 0; armed = 0;
      eh = 0; ev = 0; ee = 0; ech = 0;
    end else begin
      v = p2;
      ech = 0;
      if (v != runv) begin
        runv = v; runlen = 1; armed = 1;
      end else if (armed) begin
        runlen++;
        if (runlen == S) begin
          armed = 0;
          d = -1;
          for (int i = 0; i < 16; i++)
            if (tbl[i] == v) d = i;
          if (d >= 0) begin
            if (!ev || eh != 4'(d)) ech = 1;
            eh = 4'(d); ev = 1;
            ee = STICKY ? ee : 1'b0;
          end else if (v == 7'h7F) begin
            ev = 0;
            ee = STICKY ? ee : 1'b0;
          end else begin
            ev = 0; ee = 1;
          end
        end
      end
      p2 = p1;
      p1 = segm;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_hex", int'(hex), int'(eh));
      check("m_valid", int'(valid), int'(ev));
      check("m_err", int'(err), int'(ee));
      check("m_change", int'(change), int'(ech));
    end
  end

  task automatic hold(input logic [6:0] p, input int n);
    segm = p;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int cc;
    int bad;
    logic [6:0] r;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    // Reset / blank idle
    cc = 0;
    repeat (8) begin
      @(negedge clk);
      cc += int'(change);
    end
    check("rst_hex", int'(hex), 0);
    check("rst_valid", int'(valid), 0);
    check("rst_err", int'(err), 0);
    check("rst_change_cnt", cc, 0);
    // 24 latency: accept at edge k+5
    segm = 7'h24;
    repeat (5) @(negedge clk);
    check("lat_valid_early", int'(valid), 0);
    @(negedge clk);
    check("lat_hex", int'(hex), 2);
    check("lat_valid", int'(valid), 1);
    check("lat_change", int'(change), 1);
    check("lat_err", int'(err), 0);
    @(negedge clk);
    check("lat_change_off", int'(change), 0);
    repeat (4) @(negedge clk);
    // Glitch 19 for 2 cycles, back to 24
    bad = 0;
    segm = 7'h19;
    repeat (2) @(negedge clk);
    segm = 7'h24;
    repeat (12) begin
      @(negedge clk);
      if (change || hex != 4'h2 || !valid) bad++;
    end
    check("glitch_stable", bad, 0);
    // Illegal pattern
    segm = 7'h55;
    repeat (6) @(negedge clk);
    check("ill_err", int'(err), 1);
    check("ill_valid", int'(valid), 0);
    check("ill_hex", int'(hex), 2);
    repeat (4) @(negedge clk);
    segm = 7'h40;
    repeat (6) @(negedge clk);
    check("z_hex", int'(hex), 0);
    check("z_valid", int'(valid), 1);
    check("z_change", int'(change), 1);
    check("z_err", int'(err), int'(STICKY));
    repeat (4) @(negedge clk);
    // Blank, then walk all digits
    hold(7'h7F, 10);
    check("blank_valid", int'(valid), 0);
    cc = 0;
    for (int i = 0; i < 16; i++) begin
      segm = tbl[i];
      repeat (10) begin
        @(negedge clk);
        cc += int'(change);
      end
      check("walk_hex", int'(hex), i);
    end
    check("walk_changes", cc, 16);
    // Reset mid-settle on 30
    hold(7'h7F, 10);
    segm = 7'h30;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mr_hex", int'(hex), 0);
    check("mr_valid", int'(valid), 0);
    check("mr_err", int'(err), 0);
    check("mr_change", int'(change), 0);
    repeat (5) @(negedge clk);
    check("mr_valid_early", int'(valid), 0);
    @(negedge clk);
    check("mr_hex_acc", int'(hex), 3);
    check("mr_valid_acc", int'(valid), 1);
    check("mr_change_acc", int'(change), 1);
    // Random phase
    repeat (600) begin
      case ($urandom_range(0, 3))
        0: r = 7'h7F;
        1: r = 7'($urandom);
        default: r = tbl[$urandom_range(0, 15)];
      endcase
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      hold(r, $urandom_range(1, 9));
    end
    repeat (10) @(negedge clk);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/segm2hex.md
# segm2hex

Seven-segment pattern decoder and validator: the read side of the team's hex-to-segment encoding. It samples a 7-bit active-low segment bus and requires each pattern to hold for a configurable number of cycles before accepting it. Accepted patterns are decoded back to a 4-bit hex digit, with valid, error and change indications. The block is used to check display drivers in-system and to recover digits from segment buses that cross a clock boundary.

## Interface
- STABLE_CYCLES, 4, consecutive synchronized samples required before a pattern is accepted; legal range 2..255
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset, sampled on clk
- segm  input  7  segment bus, active-low, bit0=a … bit6=g; asynchronous to clk allowed
- hex  output  4  last accepted decoded digit
- valid  output  1  high while the last accepted pattern is a legal digit
- err  output  1  high while the last accepted pattern is neither a digit nor blank
- change  output  1  one-cycle pulse when a new legal digit is accepted

## Operation
- Input synchronizer: two flops, s1 then s2. Reset value 7'h7F (blank).
- Legal patterns (segm → hex):
  - 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7
  - 00→8, 10→9, 08→A, 03→B, 46→C, 21→D, 06→E, 0E→F
- BLANK = 7'h7F is a legal non-digit.
- Any other pattern is illegal.
- State machine, three states:
  - IDLE: reset state; blank accepted, no candidate.
  - SETTLE: candidate pattern being counted.
  - LOCKED: candidate accepted.
- Registers: candidate cand (7 bits, reset 7'h7F) and count cnt (8 bits, reset 0).
- Any state with s2 != cand: cand <= s2, cnt <= 1, next state SETTLE.
- SETTLE with s2 == cand:
  - If cnt < STABLE_CYCLES-1: cnt increments.
  - If cnt == STABLE_CYCLES-1: accept and go to LOCKED.
- LOCKED or IDLE with s2 == cand: hold. cnt does not advance, and no re-acceptance occurs.
- Acceptance effects (registered):
  - Legal digit: hex <= digit, valid <= 1, err <= 0. change <= 1 if the previous valid was 0 or the previous hex differs.
  - BLANK: valid <= 0, err <= 0, hex holds.
  - Illegal: valid <= 0, err <= 1, hex holds.
- change is 0 on every cycle that is not such an acceptance.
- Reset values: hex=0, valid=0, err=0, change=0, state IDLE.

## Timing
- Let segm be stable before edge k and held afterwards.
  - s2 shows the new pattern after edge k+1.
  - cand is loaded at edge k+2.
  - Outputs update at edge k+1+STABLE_CYCLES. With the default of 4, that is edge k+5.
- A glitch shorter than STABLE_CYCLES samples restarts counting. The outputs keep the previous accepted value.
- A pattern that returns to the current locked value after a glitch is re-accepted after full settling. change stays 0 because the digit did not change.
- Reset asserted mid-settle overrides everything on that edge: all registers take reset values, and settling restarts from blank.
- Throughput: at most one acceptance per STABLE_CYCLES cycles.

## Configuration
- SEGM2HEX_ERR_STICKY_EN defined: err, once set, stays 1 until rst_n is asserted. Later legal or blank acceptances do not clear it. valid, hex and change behave as without the macro.
- Macro undefined: err reflects only the latest accepted pattern, as described in Operation.

## Structure
- Shared package segm_pkg holds:
  - the 16 digit pattern constants and the BLANK constant
  - the state enum (IDLE, SETTLE, LOCKED)
- The same constants are reused by the encoder side.
- One sub-module, segm_lut: a combinational 7-bit-to-{is_digit, is_blank, hex[3:0]} lookup, instantiated once on s2.

## Test plan
- Reset with segm=7F: after 8 cycles, hex=0, valid=0, err=0, change never asserted.
- segm=7'h24 held from edge k, STABLE_CYCLES=4: hex=2, valid=1 at edge k+5; change high exactly one cycle; err=0.
- 7'h24 locked, then 7'h19 driven for 2 cycles, then back to 7'h24: hex stays 2, valid stays 1, change never pulses.
- segm=7'h55 (illegal) held: err=1 and valid=0 at edge k+5, hex keeps its prior value. Then 7'h40 held: hex=0, valid=1, change pulse; err=0 without the macro, err=1 with SEGM2HEX_ERR_STICKY_EN.
- Walk all 16 legal patterns, 10 cycles each: hex=0..F in order, 16 change pulses total.
- rst_n low for one cycle while settling on 7'h30: next cycle all outputs are at reset values; 7'h30 still held is accepted at reset-release edge + 1 + STABLE_CYCLES.
